// File: rtl/ball_motion_integrator.sv
// Per-ball motion stage: captures post-impact speed on a rising collision
// flag, advances position once per frame, handles the table cushions and
// applies periodic friction until the ball comes to rest.
// Optional build macro BALL_WALL_BOUNCE_EN: defined gives elastic cushions
// (speed negated on a hit), undefined gives dead cushions (speed zeroed).
module ball_motion_integrator #(
  parameter logic [10:0] X_INIT      = 11'd200,
  parameter logic [10:0] Y_INIT      = 11'd384,
  parameter logic [10:0] X_MIN       = 11'd40,
  parameter logic [10:0] X_MAX       = 11'd984,
  parameter logic [10:0] Y_MIN       = 11'd40,
  parameter logic [10:0] Y_MAX       = 11'd728,
  parameter logic [3:0]  FRIC_PERIOD = 4'd8,
  parameter logic [10:0] MAX_SPEED   = 11'd31
) (
  input  logic               vsync,
  input  logic               reset,
  input  logic               collided,
  input  logic signed [10:0] new_xspeed,
  input  logic signed [10:0] new_yspeed,
  output logic signed [10:0] x,
  output logic signed [10:0] y,
  output logic signed [10:0] xspeed,
  output logic signed [10:0] yspeed,
  output logic               moving,
  output logic               done_fric
);

  localparam int unsigned W  = 11;
  localparam int unsigned WX = 12;
  localparam int unsigned CW = 4;

  localparam logic signed [W-1:0] SPD_HI = $signed(MAX_SPEED);
  localparam logic signed [W-1:0] SPD_LO = -SPD_HI;
  localparam logic signed [W-1:0] ONE    = W'(1);
  localparam logic        [CW-1:0] FRIC_LAST = FRIC_PERIOD - CW'(1);

  typedef enum logic {
    REST   = 1'b0,
    MOVING = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic                 collided_q;
  logic        [CW-1:0] fric_cnt, fric_cnt_d;
  logic signed [W-1:0]  x_d, y_d, xspeed_d, yspeed_d;
  logic signed [W-1:0]  sat_x, sat_y;
  logic                 load;

  // Clamp a loaded speed to the allowed magnitude.
  function automatic logic signed [W-1:0] saturate(input logic signed [W-1:0] v);
    logic signed [W-1:0] r;
    r = v;
    if (v > SPD_HI) begin
      r = SPD_HI;
    end else if (v < SPD_LO) begin
      r = SPD_LO;
    end
    return r;
  endfunction

  // Move a speed one step toward zero without crossing it.
  function automatic logic signed [W-1:0] toward_zero(input logic signed [W-1:0] v);
    logic signed [W-1:0] r;
    r = v;
    if (v > 0) begin
      r = v - ONE;
    end else if (v < 0) begin
      r = v + ONE;
    end
    return r;
  endfunction

  // Advance one axis by its speed and resolve a cushion hit; returns {pos, speed}.
  function automatic logic [2*W-1:0] cushion(input logic signed [W-1:0] pos,
                                             input logic signed [W-1:0] spd,
                                             input logic [W-1:0]        lo,
                                             input logic [W-1:0]        hi);
    logic signed [WX-1:0] cand;
    logic signed [WX-1:0] lo_x;
    logic signed [WX-1:0] hi_x;
    logic signed [W-1:0]  p;
    logic signed [W-1:0]  s;
    cand = WX'(pos) + WX'(spd);
    lo_x = $signed({lo[W-1], lo});
    hi_x = $signed({hi[W-1], hi});
    p    = W'(cand);
    s    = spd;
    if (cand < lo_x || cand > hi_x) begin
      p = (cand < lo_x) ? $signed(lo) : $signed(hi);
`ifdef BALL_WALL_BOUNCE_EN
      s = -spd;
`else
      s = '0;
`endif
    end
    return {p, s};
  endfunction

  // Rising edge of the collision level is the only load trigger.
  assign load  = collided & ~collided_q;
  assign sat_x = saturate(new_xspeed);
  assign sat_y = saturate(new_yspeed);

  // State, position, speed and friction-counter registers.
  always_ff @(posedge vsync or posedge reset) begin
    if (reset) begin
      state_q    <= REST;
      collided_q <= 1'b0;
      fric_cnt   <= '0;
      x          <= $signed(X_INIT);
      y          <= $signed(Y_INIT);
      xspeed     <= '0;
      yspeed     <= '0;
    end else begin
      state_q    <= state_d;
      collided_q <= collided;
      fric_cnt   <= fric_cnt_d;
      x          <= x_d;
      y          <= y_d;
      xspeed     <= xspeed_d;
      yspeed     <= yspeed_d;
    end
  end

  // Status flags are direct decodes of the state register.
  assign moving    = (state_q == MOVING);
  assign done_fric = (state_q == REST);

  // Next-state: integrate, cushion, friction, then load override.
  always_comb begin
    state_d    = state_q;
    fric_cnt_d = fric_cnt;
    x_d        = x;
    y_d        = y;
    xspeed_d   = xspeed;
    yspeed_d   = yspeed;

    case (state_q)
      REST: begin
        if (load) begin
          xspeed_d   = sat_x;
          yspeed_d   = sat_y;
          fric_cnt_d = '0;
          if (sat_x != '0 || sat_y != '0) begin
            state_d = MOVING;
          end
        end
      end

      MOVING: begin
        {x_d, xspeed_d} = cushion(x, xspeed, X_MIN, X_MAX);
        {y_d, yspeed_d} = cushion(y, yspeed, Y_MIN, Y_MAX);
        if (load) begin
          xspeed_d   = sat_x;
          yspeed_d   = sat_y;
          fric_cnt_d = '0;
        end else if (fric_cnt == FRIC_LAST) begin
          xspeed_d   = toward_zero(xspeed_d);
          yspeed_d   = toward_zero(yspeed_d);
          fric_cnt_d = '0;
        end else begin
          fric_cnt_d = fric_cnt + CW'(1);
        end
        if (xspeed_d == '0 && yspeed_d == '0) begin
          state_d = REST;
        end
      end

      default: begin
        state_d = REST;
      end
    endcase
  end

endmodule

// File: doc/ball_motion_integrator.md
# ball_motion_integrator

Per-ball motion stage directly downstream of the cue/ball collision checker. Once per frame it captures the post-impact velocity that the checker produces, advances the ball position, handles the table cushions and applies friction. When the ball comes to rest it raises `done_fric`. The per-ball `done_fric` outputs are ANDed at top level into the checker's `done_fric_all`.

## Interface
Parameters:
- `X_INIT`, default 11'd200: x position after reset.
- `Y_INIT`, default 11'd384: y position after reset.
- `X_MIN` / `X_MAX`, default 11'd40 / 11'd984: inclusive x cushion bounds.
- `Y_MIN` / `Y_MAX`, default 11'd40 / 11'd728: inclusive y cushion bounds.
- `FRIC_PERIOD`, default 4'd8: number of frames per friction decrement. Legal range is 1–15.
- `MAX_SPEED`, default 11'd31: magnitude limit applied when a speed is loaded.

Ports (clock and reset first):
- `vsync`, in, 1: frame clock. All state updates occur on its rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `collided`, in, 1: collision flag from the checker. This is a level signal and can stay high for many frames.
- `new_xspeed`, in, signed 11: post-impact x speed. Valid whenever `collided` is high.
- `new_yspeed`, in, signed 11: post-impact y speed. Valid whenever `collided` is high.
- `x`, out, signed 11: current x position.
- `y`, out, signed 11: current y position.
- `xspeed`, out, signed 11: current x speed, in pixels per frame.
- `yspeed`, out, signed 11: current y speed, in pixels per frame.
- `moving`, out, 1: high while the block is in state MOVING.
- `done_fric`, out, 1: high while the block is in state REST.

## Operation
- Registers: a 2-state FSM (REST, MOVING), `collided_q`, a 4-bit `fric_cnt`, and position/speed registers.
- Reset (asynchronous) forces: `x`=X_INIT, `y`=Y_INIT, `xspeed`=`yspeed`=0, `collided_q`=0, `fric_cnt`=0, state REST. Therefore `done_fric`=1 and `moving`=0.
- Load event: `load` = `collided` & ~`collided_q`. `collided_q` registers `collided` every frame.
- On a load event, each new speed is saturated to [-MAX_SPEED, +MAX_SPEED]. The saturated values are written to `xspeed`/`yspeed` and `fric_cnt` is cleared.
- REST state:
  - Position is held.
  - A load event with at least one nonzero saturated speed moves the FSM to MOVING.
  - A load event with both saturated speeds zero is written but leaves the FSM in REST.
- MOVING state, per frame, in this order:
  1. Compute 12-bit candidates `nx` = x + xspeed and `ny` = y + yspeed, using the current (pre-load) speeds.
  2. Apply cushion handling per axis (see Configuration).
  3. If there is no load event:
     - If `fric_cnt` == FRIC_PERIOD-1: move each nonzero post-cushion speed one step toward 0 and set `fric_cnt` to 0.
     - Otherwise increment `fric_cnt`.
  4. If there is a load event: the saturated load speeds replace the post-cushion/friction speeds, and `fric_cnt` is cleared.
  5. If both resulting speeds are 0, go to REST. Position keeps this frame's update.
- Cushion limits are inclusive. A candidate equal to the bound is legal and is not a hit.
- Arithmetic:
  - All sums are sign-extended to 12 bits before comparison. No wrap-around is permitted.
  - The friction step never crosses zero: +1 → 0 and -1 → 0.

## Timing
- All outputs are registered. A change becomes visible immediately after the `vsync` edge that causes it.
- Load latency is one frame:
  - The first `vsync` edge with `collided` high after it was low writes the speeds and sets `moving` at that edge.
  - Position first moves with the new speed on the next edge.
- A `collided` level held high produces exactly one load. It must drop for at least one frame before another load can occur.
- `done_fric` falls on the load edge and rises on the edge where both speeds reach 0.
- Reset asserted mid-motion takes effect immediately, with no `vsync` edge needed. Release is synchronised by the top level.

## Configuration
- `BALL_WALL_BOUNCE_EN` defined: on a cushion hit, the position clamps to the violated bound and that axis speed is negated (elastic bounce). Friction in the same frame then applies to the negated speed.
- `BALL_WALL_BOUNCE_EN` undefined: the position clamps to the bound and that axis speed is set to 0 (dead cushion).

## Test plan
- Reset with x=500, xspeed=7 during MOVING → x=200, y=384, speeds 0, `done_fric`=1 asynchronously, before the next `vsync`.
- `collided` rises with new speeds (5,-3), then is held high for 10 frames → one load only. Position after 3 frames (excluding the load edge) is (215, 375). `moving`=1.
- Load (40,-50) → speeds saturate to (31,-31).
- FRIC_PERIOD=8, load (2,0) → xspeed reads 2 on frames 1–8, 1 on frames 9–16, and 0 at frame 16. `done_fric` rises on that same edge. Final x = 200+2·8+1·8 = 224.
- x=982, xspeed=+5, `BALL_WALL_BOUNCE_EN` defined → x=984, xspeed=-5. With the macro undefined → x=984, xspeed=0.
- Load edge in MOVING on a friction-tick frame → the new speeds are taken unmodified and `fric_cnt`=0. Position advanced with the old speeds on that edge.
